// File: rtl/clock_div_multi.sv
// clock_div_multi: multi-channel run-time programmable clock divider.
// Each channel produces a registered divided clock (outclk) and a one-cycle
// period-start tick. Divisor updates go through a shadow register and take
// effect only at a period boundary (wrap or sync), so outclk never glitches.
// Optional build macro CLKDIV_DUTY_EN adds a per-channel programmable duty
// threshold (duty_value) that is loaded and applied together with the divisor.
module clock_div_multi #(
  parameter int CHANNELS    = 4,
  parameter int WIDTH       = 28,
  parameter int DEFAULT_DIV = 2
) (
  input  logic                      reset,
  input  logic                      clock,
  input  logic [CHANNELS-1:0]       enable,
  input  logic                      sync,
  input  logic [CHANNELS-1:0]       div_load,
  input  logic [CHANNELS*WIDTH-1:0] div_value,
`ifdef CLKDIV_DUTY_EN
  input  logic [CHANNELS*WIDTH-1:0] duty_value,
`endif
  output logic [CHANNELS-1:0]       outclk,
  output logic [CHANNELS-1:0]       tick,
  output logic [CHANNELS-1:0]       pending
);

  localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] MIN_DIV = WIDTH'(2);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi = gi + 1) begin : g_chan
      logic [WIDTH-1:0] counter_reg;
      logic [WIDTH-1:0] active_div_reg;
      logic [WIDTH-1:0] shadow_div_reg;
      logic             outclk_reg;
      logic             tick_reg;
      logic             pending_reg;

      logic [WIDTH-1:0] load_div;     // clamped divisor from the input slice
      logic [WIDTH-1:0] apply_div;    // divisor in force after a boundary
      logic [WIDTH-1:0] counter_inc;
      logic [WIDTH-1:0] threshold;    // counter value where outclk goes high
      logic             wrap;

`ifdef CLKDIV_DUTY_EN
      logic [WIDTH-1:0] active_duty_reg;
      logic [WIDTH-1:0] shadow_duty_reg;
      logic [WIDTH-1:0] raw_duty;
      logic [WIDTH-1:0] load_duty;    // duty clamped to 1..load_div-1
      logic [WIDTH-1:0] apply_duty;

      // Clamp the incoming duty against the divisor it is loaded with.
      always_comb begin
        raw_duty = duty_value[gi*WIDTH +: WIDTH];
        if (raw_duty < ONE) begin
          load_duty = ONE;
        end else if (raw_duty > load_div - ONE) begin
          load_duty = load_div - ONE;
        end else begin
          load_duty = raw_duty;
        end
        if (div_load[gi]) begin
          apply_duty = load_duty;
        end else if (pending_reg) begin
          apply_duty = shadow_duty_reg;
        end else begin
          apply_duty = active_duty_reg;
        end
        threshold = active_duty_reg;
      end

      // Duty shadow/active registers track the divisor registers exactly.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          active_duty_reg <= DEF_DIV >> 1;
          shadow_duty_reg <= DEF_DIV >> 1;
        end else begin
          if (div_load[gi]) begin
            shadow_duty_reg <= load_duty;
          end
          if (sync || wrap) begin
            active_duty_reg <= apply_duty;
          end
        end
      end
`else
      // Without the duty option the threshold is half the divisor.
      always_comb begin
        threshold = active_div_reg >> 1;
      end
`endif

      // Divisor clamp, boundary selection and counter increment.
      always_comb begin
        load_div = div_value[gi*WIDTH +: WIDTH];
        if (load_div < MIN_DIV) begin
          load_div = MIN_DIV;
        end
        if (div_load[gi]) begin
          apply_div = load_div;
        end else if (pending_reg) begin
          apply_div = shadow_div_reg;
        end else begin
          apply_div = active_div_reg;
        end
        counter_inc = counter_reg + ONE;
        wrap        = enable[gi] && (counter_reg == active_div_reg - ONE);
      end

      // Channel state: sync beats wrap beats count; disabled channels hold.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          counter_reg    <= '0;
          active_div_reg <= DEF_DIV;
          shadow_div_reg <= DEF_DIV;
          outclk_reg     <= 1'b0;
          tick_reg       <= 1'b0;
          pending_reg    <= 1'b0;
        end else begin
          if (div_load[gi]) begin
            shadow_div_reg <= load_div;
          end
          if (sync || wrap) begin
            // Period boundary: new divisor takes effect from counter 0.
            counter_reg    <= '0;
            active_div_reg <= apply_div;
            outclk_reg     <= 1'b0;
            tick_reg       <= 1'b1;
            pending_reg    <= 1'b0;
          end else begin
            tick_reg <= 1'b0;
            if (div_load[gi]) begin
              pending_reg <= 1'b1;
            end
            if (enable[gi]) begin
              counter_reg <= counter_inc;
              outclk_reg  <= (counter_inc >= threshold);
            end
          end
        end
      end

      assign outclk[gi]  = outclk_reg;
      assign tick[gi]    = tick_reg;
      assign pending[gi] = pending_reg;
    end
  endgenerate

endmodule

// File: tb/tb_clock_div_multi.sv
// tb_clock_div_multi: randomized bench for clock_div_multi against a
// phase/divisor reference model kept in plain integer arithmetic.
module tb_clock_div_multi;
  localparam int CH = 4;
  localparam int W  = 8;

  logic              reset;
  logic              clock;
  logic [CH-1:0]     enable;
  logic              sync;
  logic [CH-1:0]     div_load;
  logic [CH*W-1:0]   div_value;
  logic [CH-1:0]     outclk;
  logic [CH-1:0]     tick;
  logic [CH-1:0]     pending;

  int checks   = 0;
  int failures = 0;

  // Reference model: phase within period, divisor in force, staged divisor.
  int phase [CH];
  int divs  [CH];
  int stage [CH];
  int pend  [CH];
  int tk    [CH];

  clock_div_multi #(.CHANNELS(CH), .WIDTH(W), .DEFAULT_DIV(2)) dut (
    .reset(reset), .clock(clock), .enable(enable), .sync(sync),
    .div_load(div_load), .div_value(div_value),
    .outclk(outclk), .tick(tick), .pending(pending)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      phase[i] = 0; divs[i] = 2; stage[i] = 2; pend[i] = 0; tk[i] = 0;
    end
  endtask

  // Advance the model by one clock using the currently driven inputs.
  task automatic model_step();
    for (int i = 0; i < CH; i++) begin
      int req;
      int nd;
      bit ld;
      bit boundary;
      ld  = div_load[i];
      req = int'(div_value[i*W +: W]);
      if (req < 2) req = 2;
      boundary = sync || (enable[i] && phase[i] == divs[i] - 1);
      if (boundary) begin
        nd = ld ? req : (pend[i] ? stage[i] : divs[i]);
        divs[i]  = nd;
        phase[i] = 0;
        pend[i]  = 0;
        tk[i]    = 1;
      end else begin
        tk[i] = 0;
        if (enable[i]) phase[i] = phase[i] + 1;
        if (ld) pend[i] = 1;
      end
      if (ld) stage[i] = req;
    end
  endtask

  task automatic compare(input string tag);
    logic [CH-1:0] eo, et, ep;
    for (int i = 0; i < CH; i++) begin
      eo[i] = (phase[i] >= divs[i] / 2);
      et[i] = tk[i][0];
      ep[i] = pend[i][0];
    end
    check({tag, ".outclk"},  32'(outclk),  32'(eo));
    check({tag, ".tick"},    32'(tick),    32'(et));
    check({tag, ".pending"}, 32'(pending), 32'(ep));
  endtask

  task automatic drive_random(input int load_pct);
    for (int i = 0; i < CH; i++) begin
      enable[i]   = ($urandom_range(0, 99) < 90);
      div_load[i] = ($urandom_range(0, 99) < load_pct);
      if ($urandom_range(0, 19) == 0)
        div_value[i*W +: W] = 8'd255;
      else
        div_value[i*W +: W] = W'($urandom_range(0, 9));
    end
    sync = ($urandom_range(0, 59) == 0);
  endtask

  task automatic run_cycles(input int n, input int load_pct, input string tag);
    for (int c = 0; c < n; c++) begin
      drive_random(load_pct);
      model_step();
      @(negedge clock);
      compare(tag);
    end
  endtask

  initial begin
    reset = 1'b1; enable = '0; sync = 1'b0; div_load = '0; div_value = '0;
    model_reset();
    repeat (2) @(negedge clock);
    compare("reset");
    reset = 1'b0;

    // Free running at the default divisor first.
    for (int c = 0; c < 6; c++) begin
      enable = '1; sync = 1'b0; div_load = '0;
      model_step();
      @(negedge clock);
      compare("default");
    end

    run_cycles(2500, 12, "random");

    // Park a pending divisor on channel 0, then reset between edges.
    enable = '0; sync = 1'b0; div_load = 4'b0001; div_value = '0;
    div_value[0 +: W] = 8'd7;
    model_step();
    @(negedge clock);
    compare("park");
    div_load = '0;
    #2;
    reset = 1'b1;
    #1;
    check("async.outclk",  32'(outclk),  32'd0);
    check("async.tick",    32'(tick),    32'd0);
    check("async.pending", 32'(pending), 32'd0);
    model_reset();
    @(negedge clock);
    compare("in_reset");
    reset = 1'b0;

    for (int c = 0; c < 8; c++) begin
      enable = '1; sync = 1'b0; div_load = '0;
      model_step();
      @(negedge clock);
      compare("post_reset");
    end

    run_cycles(800, 20, "random2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/clock_div_multi.md
Name: clock_div_multi

Overview:
- Multi-channel, run-time programmable clock divider. It is the parametrised successor to the fixed single-output divider.
- Each channel generates a divided square-wave enable clock and a one-cycle period-start tick from the system clock.
- Divisor changes are glitch-free: they are applied only at a period boundary.
- Sits between the top-level clock/reset and the pipeline/peripheral blocks that need slower strobes (display refresh, debounce, single-step).

Parameters:
- CHANNELS, 4, number of independent divider channels (1..16).
- WIDTH, 28, bit width of each channel's counter and divisor.
- DEFAULT_DIV, 2, divisor loaded into every channel at reset (must be >= 2).

Ports:
- reset  input  1  asynchronous, active-high reset
- clock  input  1  system clock, rising-edge
- enable  input  CHANNELS  per-channel run enable; low freezes the channel
- sync  input  1  one-cycle pulse; phase-aligns all channels to period start
- div_load  input  CHANNELS  per-channel strobe capturing a new divisor
- div_value  input  CHANNELS*WIDTH  divisor values; channel i uses bits [i*WIDTH +: WIDTH]
- outclk  output  CHANNELS  registered divided clock per channel
- tick  output  CHANNELS  registered one-cycle pulse at the start of each period
- pending  output  CHANNELS  high while a loaded divisor awaits application

Behaviour:
- Reset is asynchronous, active-high, on signal reset; clock is signal clock.
- Reset values, per channel:
  - counter = 0
  - active_div = DEFAULT_DIV
  - shadow_div = DEFAULT_DIV
  - outclk = 0, tick = 0, pending = 0
- Period: counter runs 0..active_div-1 and wraps to 0.
- outclk:
  - Low while counter < (active_div>>1), high otherwise.
  - Registered, updated on the same edge as counter, so it always equals (counter >= active_div>>1) and never glitches.
  - Odd divisor D: low for D>>1 cycles, high for D-(D>>1) cycles.
- tick is asserted for exactly one cycle when counter becomes 0 by a wrap or by sync. Reset does not produce a tick.
- Divisor clamp: any div_value < 2 is treated as 2. Width is unsigned WIDTH bits; maximum divisor is 2^WIDTH-1.
- div_load[i] (any cycle):
  - shadow_div[i] <= clamped slice and pending[i] <= 1.
  - A second load while pending overwrites the shadow; the last value wins.
- Application: at a wrap (enable[i]=1 and counter = active_div-1), if pending, active_div <= shadow_div and pending <= 0. The new period starts at counter 0 with the new divisor.
- Load coincident with a wrap: the value loaded in that cycle is applied at that wrap directly; pending stays 0.
- enable[i]=0: counter, outclk and active_div hold, tick = 0. A load is still captured to the shadow; application waits for the next enabled wrap.
- sync=1 (overrides enable and wrap), all channels:
  - counter <= 0, outclk <= 0, tick <= 1.
  - Pending divisors are applied immediately and pending cleared; a load in the sync cycle is applied too.
- Reset mid-period or mid-pending: returns immediately to the reset values; the pending divisor is discarded.
- Channels are fully independent except for sync.

Optional Feature:
- Macro: CLKDIV_DUTY_EN.
- With the macro defined:
  - Adds input duty_value (CHANNELS*WIDTH).
  - Loaded into a shadow duty register together with div_load and applied with the divisor at the same boundary.
  - outclk is high when counter >= active_duty.
  - active_duty is clamped to 1..active_div-1.
  - Reset value of active_duty is DEFAULT_DIV>>1.
- Without the macro: no duty_value port; threshold is fixed at active_div>>1.

Test Plan:
- Reset release, DEFAULT_DIV=2, enable=all 1 -> outclk toggles every cycle starting low; tick every 2nd cycle; pending=0.
- Channel 0 loads 5 mid-period with old divisor 4 -> pending=1 until the current period ends, then outclk low 2 / high 3 repeating, tick every 5 cycles.
- Load 0 and 1 on channel 1 -> both behave as divisor 2; no stuck output.
- Channel 2 divisor 6, enable low for 10 cycles at counter=3 -> outclk held at 1, no tick; resumes at counter 4; period completes 3 cycles after re-enable.
- Channels at divisors 3/4/7/8 free-running, sync pulse -> next cycle all counters 0, all outclk=0, all tick=1; a pending divisor on channel 3 is applied at once.
- Reset asserted asynchronously while channel 0 pending=1 -> outclk/tick/pending drop to 0 without a clock edge; after release channel 0 runs DEFAULT_DIV.
